if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i (rising edge) and rst_i.
REQ-002 clk_i  input  1  pipeline clock.
REQ-003 rst_i  input  1  synchronous reset, active high.
REQ-004 start_i  input  1  fetch enable; 0 = no fetch this cycle.
REQ-005 pc_i  input  32  current PC from the PC register.
REQ-006 instr_i  input  32  instruction-memory data for pc_i, valid in the same cycle.
REQ-007 stall_i  input  1  ID stage cannot accept an instruction this cycle.
REQ-008 flush_i  input  1  taken branch/jump in ID; discard all queued fetches.
REQ-009 instr_o  output  32  instruction presented to ID.
REQ-010 pc_plus4_o  output  32  PC+4 of the presented instruction.
REQ-011 valid_o  output  1  instr_o/pc_plus4_o are meaningful.
REQ-012 pc_hold_o  output  1  to the PC's PCWrite_i; 1 = PC holds, 0 = PC updates.

Function
REQ-013 The block SHALL hold a 2-entry FIFO of {instr, pc+4} pairs with 1-bit read/write pointers and a 2-bit count (0..2).
REQ-014 push = start_i & (count != 2) & ~flush_i; pop = valid_o & ~stall_i & ~flush_i.
REQ-015 pc_hold_o SHALL equal (count == 2), derived from registered state only; it SHALL have no combinational path from stall_i.
REQ-016 The stored pc+4 SHALL be pc_i + 32'd4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-017 When the block is not empty, instr_o/pc_plus4_o SHALL show the head entry and valid_o SHALL be 1.
REQ-018 Push+pop in the same cycle with count 1 SHALL leave count at 1 and advance both pointers.
REQ-019 At count 2, push SHALL be blocked; a pop that cycle SHALL leave count at 1, and pc_hold_o SHALL deassert on the next cycle.
REQ-020 Pointers SHALL wrap 1 -> 0 without loss or duplication of entries.
REQ-021 flush_i SHALL set count and both pointers to 0 at the next edge, regardless of stall_i or start_i; the fetch at that cycle's pc_i SHALL be dropped.
REQ-022 Pop when empty SHALL be impossible; stall_i with valid_o=0 SHALL have no effect.

Reset
REQ-023 rst_i SHALL take priority over flush_i, start_i and stall_i.
REQ-024 After a reset edge: count=0, pointers=0, valid_o=0, pc_hold_o=0, instr_o=0, pc_plus4_o=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued entries in one cycle.
REQ-026 Empty-state outputs SHALL read 0 apart from the bypass case in REQ-028.

Configuration
REQ-027 Macro IF_ID_QUEUE_BYPASS_EN SHALL select the fetch-to-ID latency.
REQ-028 With IF_ID_QUEUE_BYPASS_EN defined and count=0, a push SHALL drive valid_o=1, instr_o=instr_i and pc_plus4_o=pc_i+4 combinationally in the same cycle.
REQ-029 In that bypass case the entry SHALL be written to the FIFO only if stall_i=1; otherwise it is consumed directly and count stays 0.
REQ-030 Without IF_ID_QUEUE_BYPASS_EN, every instruction SHALL pass through the FIFO, with a 1-cycle minimum latency from push to valid_o.

Verification
REQ-031 Reset, then start_i=1, pc_i=0x00,0x04,0x08 with stall_i=0 -> pc_plus4_o=0x04,0x08,0x0C in order; pc_hold_o stays 0. Latency is 0 cycles with the macro and 1 cycle without.
REQ-032 stall_i=1 for 4 cycles with start_i=1 -> count reaches 2 and pc_hold_o=1; head instr_o is unchanged; after stall_i=0, the two queued instructions emerge in order with none lost.
REQ-033 Count=2 and flush_i=1 -> the next cycle has valid_o=0, pc_hold_o=0, count=0; the next pushed pc_i=0x40 appears with pc_plus4_o=0x44.
REQ-034 pc_i=0xFFFFFFFC pushed -> pc_plus4_o=0x00000000.
REQ-035 rst_i=1 with flush_i=1, start_i=1 and count=1 -> all outputs are 0 on the next cycle.
REQ-036 Alternate stall_i 1/0 for 20 cycles with continuous fetch -> the ID-side sequence equals the fetch sequence (pointer wrap checked), and count never exceeds 2.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for if_id_queue.
// The master side is the fetch/ID pipeline logic; the slave side is the queue.
interface if_id_queue_if;
  logic        start_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        pc_hold_o;

  modport master (
    output start_i, pc_i, instr_i, stall_i, flush_i,
    input  instr_o, pc_plus4_o, valid_o, pc_hold_o
  );

  modport slave (
    input  start_i, pc_i, instr_i, stall_i, flush_i,
    output instr_o, pc_plus4_o, valid_o, pc_hold_o
  );
endinterface

// File: rtl/if_id_queue.sv
// Two-entry IF/ID queue of {instr, pc+4} pairs with stall back-pressure and flush.
// Define IF_ID_QUEUE_BYPASS_EN for zero-latency forwarding of a fetch into an empty queue.
module if_id_queue (
  input logic    clk_i,
  input logic    rst_i,
  if_id_queue_if.slave q_if
);

  logic [31:0] r_instr [2];
  logic [31:0] r_pcp4  [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic [31:0] w_pc_plus4;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_en;
  logic        w_rd_en;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pcp4;

  assign w_pc_plus4 = q_if.pc_i + 32'd4;
  assign w_empty    = (r_count == 2'd0);
  assign w_full     = (r_count == 2'd2);
  assign w_push     = q_if.start_i & ~w_full & ~q_if.flush_i;
  assign w_pop      = w_valid & ~q_if.stall_i & ~q_if.flush_i;
  // A pop while empty can only be the bypass path; that entry never touches storage.
  assign w_wr_en    = w_push & ~(w_empty & w_pop);
  assign w_rd_en    = w_pop & ~w_empty;

  always_comb begin
    w_valid = 1'b0;
    w_instr = '0;
    w_pcp4  = '0;
    if (!w_empty) begin
      w_valid = 1'b1;
      w_instr = r_instr[r_rd_ptr];
      w_pcp4  = r_pcp4[r_rd_ptr];
    end
`ifdef IF_ID_QUEUE_BYPASS_EN
    else if (q_if.start_i && !q_if.flush_i) begin
      w_valid = 1'b1;
      w_instr = q_if.instr_i;
      w_pcp4  = w_pc_plus4;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pcp4[i]  <= '0;
      end
    end else if (q_if.flush_i) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_instr[r_wr_ptr] <= q_if.instr_i;
        r_pcp4[r_wr_ptr]  <= w_pc_plus4;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_rd_en) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Hold comes from registered occupancy only, so stall_i never reaches the PC enable.
  assign q_if.pc_hold_o  = w_full;
  assign q_if.valid_o    = w_valid;
  assign q_if.instr_o    = w_instr;
  assign q_if.pc_plus4_o = w_pcp4;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: fetches are queued as expected entries and
// compared when the ID side consumes them; scenario tasks add targeted checks.
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } item_t;

`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  if_id_queue_if bif();

  if_id_queue dut (
    .clk_i (clk),
    .rst_i (rst),
    .q_if  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  item_t       sb[$];
  logic [31:0] got_q[$];
  logic [31:0] fetched_q[$];
  logic        obs_valid;
  logic        obs_hold;
  logic [31:0] obs_instr;
  logic [31:0] obs_pcp4;
  logic        last_push;

  // One clock: sample outputs at negedge, compare against the scoreboard, advance.
  task automatic sb_cycle();
    item_t head;
    logic  exp_valid;
    logic  push;
    logic  pop;
    head = '0;
    @(negedge clk);
    obs_valid = bif.valid_o;
    obs_hold  = bif.pc_hold_o;
    obs_instr = bif.instr_o;
    obs_pcp4  = bif.pc_plus4_o;
    push      = bif.start_i && !bif.flush_i && (sb.size() != 2);
    last_push = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      exp_valid = (sb.size() != 0);
      if (exp_valid) head = sb[0];
      else if (BYPASS && push) begin
        exp_valid = 1'b1;
        head.instr = bif.instr_i;
        head.pcp4  = bif.pc_i + 32'd4;
      end
      checks++;
      if (obs_hold !== (sb.size() == 2)) begin
        errors++;
        $display("FAIL pc_hold: got %b expected %b (t=%0t)", obs_hold, sb.size() == 2, $time);
      end
      checks++;
      if (obs_valid !== exp_valid) begin
        errors++;
        $display("FAIL valid: got %b expected %b (t=%0t)", obs_valid, exp_valid, $time);
      end
      checks++;
      if (obs_instr !== head.instr || obs_pcp4 !== head.pcp4) begin
        errors++;
        $display("FAIL head: got instr=%h pcp4=%h expected instr=%h pcp4=%h (t=%0t)",
                 obs_instr, obs_pcp4, head.instr, head.pcp4, $time);
      end
      pop = exp_valid && !bif.stall_i && !bif.flush_i;
      if (bif.flush_i) begin
        sb.delete();
      end else begin
        if (push) begin
          sb.push_back('{instr: bif.instr_i, pcp4: bif.pc_i + 32'd4});
          fetched_q.push_back(bif.pc_i + 32'd4);
          last_push = 1'b1;
        end
        if (pop) begin
          void'(sb.pop_front());
          got_q.push_back(obs_pcp4);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [31:0] pc, input logic stl, input logic fl);
    bif.start_i = st;
    bif.pc_i    = pc;
    bif.instr_i = $urandom;
    bif.stall_i = stl;
    bif.flush_i = fl;
  endtask

  task automatic drain(input int n);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (n) sb_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) sb_cycle();
    rst = 1'b0;
    sb_cycle();
    checks++;
    if (obs_valid !== 1'b0 || obs_hold !== 1'b0 || obs_instr !== 32'h0 || obs_pcp4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b hold=%b instr=%h pcp4=%h expected all 0",
               obs_valid, obs_hold, obs_instr, obs_pcp4);
    end
  endtask

  task automatic test_stream();
    got_q.delete();
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    sb_cycle();
    checks++;
    if (obs_valid !== BYPASS) begin
      errors++;
      $display("FAIL stream_latency: got valid=%b expected %b", obs_valid, BYPASS);
    end
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    sb_cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    sb_cycle();
    drain(3);
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 32'h4 || got_q[1] !== 32'h8 || got_q[2] !== 32'hC) begin
      errors++;
      $display("FAIL stream_order: got %p expected 4,8,c", got_q);
    end
  endtask

  task automatic test_stall_full();
    logic [31:0] first_instr;
    got_q.delete();
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    first_instr = bif.instr_i;
    sb_cycle();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      sb_cycle();
    end
    checks++;
    if (obs_hold !== 1'b1 || obs_instr !== first_instr || obs_pcp4 !== 32'h104) begin
      errors++;
      $display("FAIL stall_full: got hold=%b instr=%h pcp4=%h expected 1 %h 104",
               obs_hold, obs_instr, obs_pcp4, first_instr);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    sb_cycle();
    sb_cycle();
    checks++;
    if (obs_hold !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got %b expected 0", obs_hold);
    end
    drain(2);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'h104 || got_q[1] !== 32'h108) begin
      errors++;
      $display("FAIL stall_order: got %p expected 104,108", got_q);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h200, 1'b1, 1'b0);
    sb_cycle();
    drive(1'b1, 32'h204, 1'b1, 1'b0);
    sb_cycle();
    drive(1'b1, 32'h208, 1'b1, 1'b1);
    sb_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    sb_cycle();
    checks++;
    if (obs_valid !== 1'b0 || obs_hold !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got valid=%b hold=%b expected 0 0", obs_valid, obs_hold);
    end
    got_q.delete();
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    sb_cycle();
    drain(3);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h44) begin
      errors++;
      $display("FAIL flush_refetch: got %p expected 44", got_q);
    end
  endtask

  task automatic test_wrap_pc();
    got_q.delete();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    sb_cycle();
    drain(3);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap: got %p expected 0", got_q);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h300, 1'b1, 1'b0);
    sb_cycle();
    rst = 1'b1;
    drive(1'b1, 32'h304, 1'b1, 1'b1);
    sb_cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    sb_cycle();
    checks++;
    if (obs_valid !== 1'b0 || obs_hold !== 1'b0 || obs_instr !== 32'h0 || obs_pcp4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b hold=%b instr=%h pcp4=%h expected all 0",
               obs_valid, obs_hold, obs_instr, obs_pcp4);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    int          bad;
    got_q.delete();
    fetched_q.delete();
    pc = 32'h500;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, pc, (i % 2 == 0), 1'b0);
      sb_cycle();
      if (last_push) pc = pc + 32'd4;
    end
    drain(4);
    bad = 0;
    if (got_q.size() != fetched_q.size() || got_q.size() < 8) bad = 1;
    else foreach (got_q[k]) if (got_q[k] !== fetched_q[k]) bad = 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL alt_stall_order: got %0d items %p expected %0d items %p",
               got_q.size(), got_q, fetched_q.size(), fetched_q);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_stall_full();
    test_flush();
    test_wrap_pc();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
